calc_sequencer: RTL and testbench

//  Top-level sequencer for the two-operand button calculator. It debounces the push button and

---
 rtl/calc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Two-operand button calculator sequencer.
// Debounces the button, captures A / B+op, runs the ALU, holds the result.
module calc_sequencer #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 button,
   input  logic [WIDTH-1:0]     din,
   input  logic [1:0]           op,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy,
   output logic                 show_result,
   output logic [1:0]           state_dbg
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = 2 * WIDTH;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   typedef enum logic [1:0] {
      WAIT_A  = 2'd0,
      WAIT_B  = 2'd1,
      COMPUTE = 2'd2,
      SHOW    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              db_level_q, db_level_d;
   logic              db_dly_q;
   logic              press;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic [RW-1:0]     result_q, result_d;
   logic [RW-1:0]     acc_q, acc_d;
   logic [RW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [SW-1:0]     step_q, step_d;
   logic [RW-1:0]     a_ext, b_ext, partial;

   assign a_ext = {{WIDTH{1'b0}}, a_q};
   assign b_ext = {{WIDTH{1'b0}}, b_q};

   // Debounced level flips only after a full run of mismatching samples
   always_comb begin
      cnt_d      = '0;
      db_level_d = db_level_q;
      if (button != db_level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_level_d = button;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // One-cycle pulse on a debounced rising edge only
   assign press = db_level_q & ~db_dly_q;

   // Next-state and datapath; mul is shift-add, one multiplier bit per cycle
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      step_d   = step_q;
      partial  = acc_q + (mplier_q[0] ? mcand_q : '0);
      unique case (state_q)
         WAIT_A: begin
            if (press) begin
               a_d     = din;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (press) begin
               b_d      = din;
               op_d     = op;
               acc_d    = '0;
               mcand_d  = a_ext;
               mplier_d = din;
               step_d   = '0;
               state_d  = COMPUTE;
            end
         end
         COMPUTE: begin
            unique case (op_q)
               OP_ADD: begin
                  result_d = a_ext + b_ext;
                  state_d  = SHOW;
               end
               OP_SUB: begin
                  result_d = {{WIDTH{1'b0}}, a_q - b_q};
                  state_d  = SHOW;
               end
               OP_AND: begin
                  result_d = a_ext & b_ext;
                  state_d  = SHOW;
               end
               OP_MUL: begin
                  acc_d    = partial;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  step_d   = step_q + SW'(1);
                  if (step_q == SW'(WIDTH - 1)) begin
                     result_d = partial;
                     state_d  = SHOW;
                  end
               end
            endcase
         end
         SHOW: begin
            if (press) begin
               state_d = WAIT_A;
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_A;
         cnt_q      <= '0;
         db_level_q <= 1'b0;
         db_dly_q   <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         result_q   <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         step_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         db_level_q <= db_level_d;
         db_dly_q   <= db_level_q;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         result_q   <= result_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         step_q     <= step_d;
      end
   end

   assign result      = result_q;
   assign busy        = (state_q == COMPUTE);
   assign show_result = (state_q == SHOW);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer.
// Table vectors, random ops vs. arithmetic model, debounce/abort corners.
module tb_calc_sequencer;

   localparam int W  = 8;
   localparam int DB = 4;

   logic           clk;
   logic           rst_n;
   logic           button;
   logic [W-1:0]   din;
   logic [1:0]     op;
   logic [2*W-1:0] result;
   logic           busy;
   logic           show_result;
   logic [1:0]     state_dbg;

   int n_pass;
   int n_total;
   int busy_cycles;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [1:0]  o;
      logic [15:0] exp_r;
      int          exp_busy;
   } vec_t;

   vec_t vecs[8];

   calc_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .button      (button),
      .din         (din),
      .op          (op),
      .result      (result),
      .busy        (busy),
      .show_result (show_result),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   function automatic int model(input int a, input int b, input int o);
      case (o)
         0: return a + b;
         1: return (a - b + 256) % 256;
         2: return a * b;
         default: return a & b;
      endcase
   endfunction

   task automatic press(input logic [7:0] v, input logic [1:0] o);
      din    = v;
      op     = o;
      button = 1'b1;
      repeat (DB + 1) tick();
      button = 1'b0;
      din    = 8'($urandom);
      op     = 2'($urandom);
      repeat (DB + 1) tick();
   endtask

   task automatic wait_show(input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (show_result === 1'b1) seen = 1;
         else tick();
      end
      chk({tag, "_show_seen"}, seen, 1);
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] o, input logic [15:0] exp_r,
                        input int exp_busy, input string tag);
      chk({tag, "_idle"}, state_dbg, 0);
      press(a, 2'($urandom));
      chk({tag, "_wait_b"}, state_dbg, 1);
      busy_cycles = 0;
      press(b, o);
      wait_show(tag);
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_busy_cycles"}, busy_cycles, exp_busy);
      repeat (3) tick();
      chk({tag, "_show_hold"}, state_dbg, 3);
      press(8'($urandom), 2'($urandom));
      chk({tag, "_back_a"}, state_dbg, 0);
      chk({tag, "_show_low"}, show_result, 0);
      chk({tag, "_result_kept"}, result, exp_r);
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      busy_cycles = 0;
      rst_n       = 1'b0;
      button      = 1'b0;
      din         = '0;
      op          = '0;

      vecs[0] = '{8'h0F, 8'h03, 2'b00, 16'h0012, 1};
      vecs[1] = '{8'hFF, 8'hFF, 2'b10, 16'hFE01, 8};
      vecs[2] = '{8'h03, 8'h05, 2'b01, 16'h00FE, 1};
      vecs[3] = '{8'hF0, 8'h3C, 2'b11, 16'h0030, 1};
      vecs[4] = '{8'hFF, 8'h01, 2'b00, 16'h0100, 1};
      vecs[5] = '{8'h00, 8'h01, 2'b01, 16'h00FF, 1};
      vecs[6] = '{8'h00, 8'hFF, 2'b10, 16'h0000, 8};
      vecs[7] = '{8'h80, 8'h02, 2'b10, 16'h0100, 8};

      repeat (2) tick();
      chk("rst_state", state_dbg, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_show", show_result, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].exp_r,
               vecs[i].exp_busy, $sformatf("vec%0d", i));
      end

      for (int w = 1; w < DB; w++) begin
         button = 1'b1;
         repeat (w) tick();
         button = 1'b0;
         repeat (DB + 2) tick();
         chk($sformatf("glitch%0d", w), state_dbg, 0);
      end

      din    = 8'h20;
      op     = 2'b11;
      button = 1'b0; tick();
      button = 1'b1; tick();
      button = 1'b0; tick();
      button = 1'b1;
      repeat (20) tick();
      chk("bounce_one_press", state_dbg, 1);
      button = 1'b0;
      repeat (10) tick();
      chk("release_no_press", state_dbg, 1);
      press(8'h01, 2'b00);
      wait_show("bounce");
      chk("bounce_result", result, 16'h0021);
      press(8'h00, 2'b00);
      chk("bounce_back_a", state_dbg, 0);

      press(8'hFF, 2'b00);
      busy_cycles = 0;
      din    = 8'hFF;
      op     = 2'b10;
      button = 1'b1;
      repeat (DB) tick();
      button = 1'b0;
      repeat (DB) tick();
      button = 1'b1;
      repeat (DB - 1) tick();
      button = 1'b0;
      tick();
      din = 8'h00;
      op  = 2'b00;
      wait_show("mulpress");
      chk("mulpress_result", result, 16'hFE01);
      chk("mulpress_busy", busy_cycles, 8);
      repeat (10) tick();
      chk("mulpress_still_show", state_dbg, 3);
      press(8'h00, 2'b00);
      chk("mulpress_back_a", state_dbg, 0);

      press(8'hFF, 2'b00);
      din    = 8'hFF;
      op     = 2'b10;
      button = 1'b1;
      repeat (DB) tick();
      button = 1'b0;
      repeat (DB) tick();
      chk("abort_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_state", state_dbg, 0);
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      do_op(8'h12, 8'h34, 2'b10, 16'h03A8, 8, "post_rst");

      for (int k = 0; k < 25; k++) begin
         logic [7:0] ra, rb;
         logic [1:0] ro;
         int         er;
         ra = 8'($urandom);
         rb = 8'($urandom);
         ro = 2'($urandom);
         er = model(int'(ra), int'(rb), int'(ro));
         do_op(ra, rb, ro, 16'(er), (ro == 2'b10) ? 8 : 1,
               $sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
